// File: rtl/wave_capture.sv
`default_nettype none
// ============================================================================
// Module      : wave_capture
// Description : Triggered sample recorder. It arms, waits for a rising crossing
//               of trig_level, then stores 2**ADDR_WIDTH accepted samples in RAM.
//               Optional macro CAPTURE_DECIMATE_EN adds the decim input and
//               accepts one sample in every decim+1.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
`ifdef CAPTURE_DECIMATE_EN
  input  logic [7:0]            decim,
`endif
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            state,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wr_ptr
);

  localparam logic [1:0] c_idle    = 2'b00;
  localparam logic [1:0] c_armed   = 2'b01;
  localparam logic [1:0] c_capture = 2'b10;
  localparam logic [1:0] c_done    = 2'b11;
  localparam int         c_depth   = 2**ADDR_WIDTH;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_prev_vld;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  logic                  w_accept;
  logic                  w_trigger;
  logic                  w_enter_armed;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  assign w_enter_armed = arm && ((r_state == c_idle) || (r_state == c_done));

`ifdef CAPTURE_DECIMATE_EN
  logic [7:0] r_div;

  // Divider restarts on arming so the first sample after arm is always accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= 8'd0;
    end else if (w_enter_armed) begin
      r_div <= 8'd0;
    end else if (din_vld) begin
      r_div <= (r_div == decim) ? 8'd0 : r_div + 8'd1;
    end
  end

  assign w_accept = din_vld && (r_div == 8'd0);
`else
  assign w_accept = din_vld;
`endif

  assign w_trigger = (r_state == c_armed) && w_accept && r_prev_vld &&
                     (r_prev < trig_level) && (din >= trig_level);

  // Reset must not disturb RAM contents, so writes are blocked during rst.
  assign w_wr_en   = !rst && (w_trigger || ((r_state == c_capture) && w_accept));
  assign w_wr_addr = w_trigger ? '0 : r_wr_ptr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:    if (arm) w_next_state = c_armed;
      c_armed:   if (w_trigger) w_next_state = c_capture;
      c_capture: if (w_accept && (&r_wr_ptr)) w_next_state = c_done;
      c_done:    if (arm) w_next_state = c_armed;
      default:   w_next_state = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    state = r_state;
    done  = (r_state == c_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_enter_armed) begin
        r_prev_vld <= 1'b0;
      end else if ((r_state == c_armed) && w_accept) begin
        r_prev     <= din;
        r_prev_vld <= 1'b1;
      end
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= din;
    end
  end

  // Read-first: a same-cycle write to rd_addr is not visible until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
  assign wr_ptr  = r_wr_ptr;

endmodule
`default_nettype wire
